// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Elastic pipelined ALU with branch-compare mode, flush and
//               valid/ready result handshake toward the CDB.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int STAGES    = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      opr1_in,
    input  logic [XLEN-1:0]      opr2_in,
    input  logic [ROB_WIDTH-1:0] rob_id_in,
    input  logic [2:0]           op_l1_in,
    input  logic                 op_l2_in,
    input  logic                 br_mode_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      value_out,
    output logic [ROB_WIDTH-1:0] rob_id_out
);

    localparam int SHW  = $clog2(XLEN);
    localparam int LAST = STAGES - 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SRL  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    logic [STAGES-1:0]                valid_q, valid_d;
    logic [STAGES-1:0][XLEN-1:0]      value_q, value_d;
    logic [STAGES-1:0][ROB_WIDTH-1:0] tag_q,   tag_d;

    logic [SHW-1:0]    shamt;
    logic              lt_s;
    logic              lt_u;
    logic              taken;
    logic [XLEN-1:0]   alu_res;

    logic              en;
    logic              down_ok;
    logic [STAGES-1:0] move;
    logic              in_ready_w;
    logic              accept;

    always_comb begin
        shamt   = opr2_in[SHW-1:0];
        lt_s    = $signed(opr1_in) < $signed(opr2_in);
        lt_u    = opr1_in < opr2_in;
        taken   = 1'b0;
        alu_res = '0;
        if (br_mode_in) begin
            case (op_l1_in)
                BR_EQ:   taken = (opr1_in == opr2_in);
                BR_NE:   taken = (opr1_in != opr2_in);
                BR_LT:   taken = lt_s;
                BR_GE:   taken = !lt_s;
                BR_LTU:  taken = lt_u;
                BR_GEU:  taken = !lt_u;
                default: taken = 1'b0;
            endcase
            alu_res = {{(XLEN-1){1'b0}}, taken};
        end else begin
            case (op_l1_in)
                OP_ADD:  alu_res = op_l2_in ? (opr1_in - opr2_in) : (opr1_in + opr2_in);
                OP_SLL:  alu_res = opr1_in << shamt;
                OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
                OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
                OP_XOR:  alu_res = opr1_in ^ opr2_in;
                OP_SRL:  alu_res = op_l2_in ? XLEN'($signed(opr1_in) >>> shamt)
                                            : (opr1_in >> shamt);
                OP_OR:   alu_res = opr1_in | opr2_in;
                OP_AND:  alu_res = opr1_in & opr2_in;
                default: alu_res = '0;
            endcase
        end
    end

    // Walk from the output back to stage 0: each stage may advance when the
    // stage ahead of it is empty or is itself advancing this cycle.
    always_comb begin
        en      = rdy_in && !flush_in;
        move    = '0;
        down_ok = out_ready;
        for (int i = LAST; i >= 0; i--) begin
            move[i] = en && valid_q[i] && down_ok;
            down_ok = !valid_q[i] || move[i];
        end
        in_ready_w = rst_in && en && down_ok;
        accept     = in_valid && in_ready_w;
    end

    always_comb begin
        valid_d = valid_q;
        value_d = value_q;
        tag_d   = tag_q;

        valid_d[0] = accept || (valid_q[0] && !move[0]);
        if (accept) begin
            value_d[0] = alu_res;
            tag_d[0]   = rob_id_in;
        end

        for (int i = 1; i < STAGES; i++) begin
            valid_d[i] = move[i-1] || (valid_q[i] && !move[i]);
            if (move[i-1]) begin
                value_d[i] = value_q[i-1];
                tag_d[i]   = tag_q[i-1];
            end
        end

        if (flush_in) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
            value_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        in_ready   = in_ready_w;
        out_valid  = valid_q[LAST];
        value_out  = value_q[LAST];
        rob_id_out = tag_q[LAST];
    end

endmodule
`default_nettype wire
